prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameters SHALL be: DEPTH, default 64, code-memory words; RST_HOLD, default 2, cycles CPU reset is held after load.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to (re)load program.
REQ-005 ld_valid  in  1  loader word available.
REQ-006 ld_data  in  16  instruction word.
REQ-007 ld_last  in  1  qualifies final word of program.
REQ-008 ld_ready  out  1  block accepts word this cycle.
REQ-009 im_we  out  1  code-memory write enable.
REQ-010 im_waddr  out  6  code-memory write address.
REQ-011 im_wdata  out  16  code-memory write data.
REQ-012 cpu_rst  out  1  reset to CPU core, active-high.
REQ-013 busy  out  1  high in CLEAR, LOAD and RELEASE.
REQ-014 done  out  1  high in RUN.
REQ-015 err  out  1  sticky overflow: DEPTH words accepted without ld_last.
REQ-016 word_count  out  7  words accepted in current load, 0..64.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, LOAD, RELEASE, RUN; state is registered.
REQ-018 IDLE: cpu_rst=1, ld_ready=0; start -> CLEAR.
REQ-019 CLEAR: one write per cycle of 16'h0000 to addresses 0..DEPTH-1 in ascending order (DEPTH cycles); after address DEPTH-1 -> LOAD.
REQ-020 LOAD: ld_ready=1; a word is accepted in any cycle with ld_valid=1 and ld_ready=1.
REQ-021 ld_ready SHALL be decoded from registered state only, with no combinational path from ld_valid.
REQ-022 An accepted word SHALL produce im_we=1, im_waddr=word_count(pre-increment), im_wdata=ld_data in the following cycle (1-cycle latency); word_count then increments.
REQ-023 ld_valid=0 cycles in LOAD SHALL hold word_count and produce im_we=0.
REQ-024 An accepted word with ld_last=1 -> RELEASE; ld_ready=0 from the next cycle.
REQ-025 Acceptance of word DEPTH without ld_last SHALL set err=1 and -> RELEASE; no write beyond address DEPTH-1 is issued.
REQ-026 RELEASE: cpu_rst=1 for exactly RST_HOLD cycles, then -> RUN.
REQ-027 RUN: cpu_rst=0, done=1, im_we=0; start -> CLEAR, with cpu_rst=1 from the next cycle.
REQ-028 start SHALL be ignored in CLEAR, LOAD and RELEASE.
REQ-029 On entry to CLEAR, word_count and err SHALL clear to 0.
REQ-030 im_we SHALL be 0 outside CLEAR and the cycle following an acceptance in LOAD.
REQ-031 cpu_rst SHALL be 1 in every state except RUN.

Reset
REQ-032 rst SHALL force IDLE with cpu_rst=1 and all other outputs 0 (im_waddr=0, im_wdata=0, word_count=0, err=0) in the cycle after the sampled edge, from any state, including mid-CLEAR and mid-LOAD.
REQ-033 A pending delayed write SHALL be discarded when rst is sampled high.

Structure
REQ-034 State encoding, DEPTH/RST_HOLD defaults and the 16-bit NOP constant SHALL reside in the shared CPU package.
REQ-035 One sub-module SHALL be used: hold_counter, a loadable down-counter used for CLEAR addressing and RELEASE timing; all else is flat.
REQ-036 At top level, im_we/im_waddr/im_wdata drive the code-memory write port; cpu_rst ORs into the CPU core reset.

Verification
REQ-037 start; after 64 CLEAR cycles, 3 words 0x1234, 0x5678, 0x9ABC (last on 3rd) -> writes at addr 0,1,2; word_count=3; cpu_rst low 2 cycles after RELEASE entry; done=1; err=0.
REQ-038 ld_valid toggled every other cycle for 5 words -> 5 writes, consecutive addresses, no duplicates; im_we low on idle cycles.
REQ-039 64 words, none with ld_last -> 64th written at addr 63; err=1; ld_ready=0; RUN reached; no write to addr 0 after CLEAR.
REQ-040 rst asserted after 2nd accepted word -> next cycle IDLE, im_we=0, word_count=0, cpu_rst=1; delayed 2nd write not issued.
REQ-041 start in RUN after program load -> cpu_rst=1 next cycle; CLEAR writes 0 to addr 0..63; word_count and err clear.
REQ-042 start pulsed during CLEAR and LOAD -> no effect on state sequence or cycle counts.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, sizing defaults
// and the NOP word used to scrub code memory before a load.
package prog_loader_pkg;

  localparam int DEPTH_DEF    = 64;
  localparam int RST_HOLD_DEF = 2;
  localparam int AW           = 6;
  localparam int CW           = 7;
  localparam int DW           = 16;

  localparam logic [DW-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  // CLEAR walks upward while the counter walks down, so the next address is depth - remaining.
  function automatic logic [AW-1:0] clear_next_addr(input logic [CW-1:0] remaining,
                                                    input int depth);
    clear_next_addr = AW'(depth - int'(remaining));
  endfunction

endpackage

// File: rtl/prog_loader_hold_counter.sv
// Loadable down-counter shared by CLEAR addressing and RELEASE hold timing.
// Load wins over decrement; decrement stops at zero.
module hold_counter
  import prog_loader_pkg::*;
#(
  parameter int W = CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader: scrubs code memory, streams a program into it, then holds the
// CPU in reset for a fixed time before releasing it. All outputs are registered.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [DW-1:0] im_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_count
);

  state_e        state_r;
  state_e        state_nxt_s;
  logic          ld_ready_r;
  logic          im_we_r;
  logic [AW-1:0] im_waddr_r;
  logic [DW-1:0] im_wdata_r;
  logic          cpu_rst_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic [CW-1:0] word_count_r;

  logic          we_nxt_s;
  logic [AW-1:0] waddr_nxt_s;
  logic [DW-1:0] wdata_nxt_s;
  logic          err_nxt_s;
  logic [CW-1:0] wc_nxt_s;
  logic          accept_s;

  logic          cnt_load_s;
  logic [CW-1:0] cnt_val_s;
  logic          cnt_dec_s;
  logic [CW-1:0] cnt_value_s;
  logic          cnt_zero_s;

  hold_counter #(.W(CW)) u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .count    (cnt_value_s),
    .zero     (cnt_zero_s)
  );

  // ld_ready is a register, so acceptance never depends combinationally on itself
  assign accept_s = ld_valid && ld_ready_r;

  // Next-state, counter control and next write-port values
  always_comb begin
    state_nxt_s = state_r;
    cnt_load_s  = 1'b0;
    cnt_val_s   = '0;
    cnt_dec_s   = 1'b0;
    we_nxt_s    = 1'b0;
    waddr_nxt_s = '0;
    wdata_nxt_s = NOP_WORD;
    wc_nxt_s    = word_count_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_nxt_s = ST_CLEAR;
          cnt_load_s  = 1'b1;
          cnt_val_s   = CW'(DEPTH - 1);
          we_nxt_s    = 1'b1;
          waddr_nxt_s = '0;
          wc_nxt_s    = '0;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CLEAR: begin
        if (cnt_zero_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          cnt_dec_s   = 1'b1;
          we_nxt_s    = 1'b1;
          waddr_nxt_s = clear_next_addr(cnt_value_s, DEPTH);
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          we_nxt_s    = 1'b1;
          waddr_nxt_s = word_count_r[AW-1:0];
          wdata_nxt_s = ld_data;
          wc_nxt_s    = word_count_r + CW'(1);
          if (ld_last) begin
            state_nxt_s = ST_RELEASE;
            cnt_load_s  = 1'b1;
            cnt_val_s   = CW'(RST_HOLD - 1);
          end else if (word_count_r == CW'(DEPTH - 1)) begin
            // Memory is full and no terminator arrived: flag overflow and boot anyway
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_RELEASE;
            cnt_load_s  = 1'b1;
            cnt_val_s   = CW'(RST_HOLD - 1);
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        if (cnt_zero_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; flags are decoded from the next state so they track state_r
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ld_ready_r   <= 1'b0;
      im_we_r      <= 1'b0;
      im_waddr_r   <= '0;
      im_wdata_r   <= NOP_WORD;
      cpu_rst_r    <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      word_count_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      ld_ready_r   <= (state_nxt_s == ST_LOAD);
      im_we_r      <= we_nxt_s;
      im_waddr_r   <= waddr_nxt_s;
      im_wdata_r   <= wdata_nxt_s;
      cpu_rst_r    <= (state_nxt_s != ST_RUN);
      busy_r       <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_LOAD) ||
                      (state_nxt_s == ST_RELEASE);
      done_r       <= (state_nxt_s == ST_RUN);
      err_r        <= err_nxt_s;
      word_count_r <= wc_nxt_s;
    end
  end

  assign ld_ready   = ld_ready_r;
  assign im_we      = im_we_r;
  assign im_waddr   = im_waddr_r;
  assign im_wdata   = im_wdata_r;
  assign cpu_rst    = cpu_rst_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign word_count = word_count_r;

endmodule
